// File: rtl/lu_serial_seq.sv
// Bit-serial sequencer that feeds one shared 1-bit logic unit cell LSB first
// and assembles a WIDTH-bit result behind valid/ready handshakes.

module lu_cell (
  input  logic a,
  input  logic b,
  input  logic select_op,
  input  logic select_group,
  output logic final_out
);
  logic base;

  // select_group picks OR over AND; select_op clear inverts (NAND/NOR)
  assign base      = select_group ? (a | b) : (a & b);
  assign final_out = select_op ? base : ~base;
endmodule

module lu_serial_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_op,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [1:0]       op_r;
  logic [CW-1:0]    cnt;
  logic             lu_out;

  lu_cell u_lu (
    .a            (a_sr[0]),
    .b            (b_sr[0]),
    .select_op    (op_r[0]),
    .select_group (op_r[1]),
    .final_out    (lu_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_r   <= 2'b00;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= in_a;
            b_sr  <= in_b;
            op_r  <= in_op;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // result fills from the MSB end so bit i lands in place after WIDTH shifts
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {lu_out, res_sr[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_result = res_sr;
  assign out_op     = op_r;
endmodule
